// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and write-port record for the MIPS register file
package rf_pkg;

   localparam int RF_DATA_W = 16;
   localparam int RF_ADDR_W = 3;
   localparam int RF_R0     = 0;

   typedef struct packed {
      logic                 we;
      logic [RF_ADDR_W-1:0] addr;
      logic [RF_DATA_W-1:0] data;
   } wr_port_t;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy scoreboard, issue sets and writeback clears
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int ADDR_W  = RF_ADDR_W,
   parameter int ZERO_R0 = 0,
   parameter int DEPTH   = 1 << ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bset,
   input  logic [ADDR_W-1:0] bset_addr,
   input  logic              we0,
   input  logic [ADDR_W-1:0] waddr0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] waddr1,
   output logic [DEPTH-1:0]  busy
);

   logic [DEPTH-1:0] busy_next;

   // A newly issued producer outranks a writeback landing on the same register.
   always_comb begin
      busy_next = busy;
      for (int i = 0; i < DEPTH; i++) begin
         if (bset && bset_addr == ADDR_W'(i))
            busy_next[i] = 1'b1;
         else if ((we0 && waddr0 == ADDR_W'(i)) || (we1 && waddr1 == ADDR_W'(i)))
            busy_next[i] = 1'b0;
      end
      if (ZERO_R0 != 0)
         busy_next[RF_R0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         busy <= '0;
      else
         busy <= busy_next;
   end

endmodule

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-port register file with dual write, bypass and busy scoreboard
module register_file_mp
   import rf_pkg::*;
#(
   parameter int DATA_W  = RF_DATA_W,
   parameter int ADDR_W  = RF_ADDR_W,
   parameter int NUM_RD  = 2,
   parameter int ZERO_R0 = 0,
   parameter int BYPASS  = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we0,
   input  logic [ADDR_W-1:0]        waddr0,
   input  logic [DATA_W-1:0]        wdata0,
   input  logic                     we1,
   input  logic [ADDR_W-1:0]        waddr1,
   input  logic [DATA_W-1:0]        wdata1,
   input  logic [NUM_RD*ADDR_W-1:0] raddr,
   output logic [NUM_RD*DATA_W-1:0] rdata,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     bset,
   input  logic [ADDR_W-1:0]        bset_addr,
   output logic [(1<<ADDR_W)-1:0]   busy
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] R0 = ADDR_W'(RF_R0);

   logic [DATA_W-1:0] mem [DEPTH];
   logic              wr0_ok;
   logic              wr1_ok;

   assign wr0_ok = we0 && !(ZERO_R0 != 0 && waddr0 == R0);
   assign wr1_ok = we1 && !(ZERO_R0 != 0 && waddr1 == R0);

   // Port 1 is written last so it wins a same-address collision.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (wr0_ok)
            mem[waddr0] <= wdata0;
         if (wr1_ok)
            mem[waddr1] <= wdata1;
      end
   end

   rf_scoreboard #(
      .ADDR_W  (ADDR_W),
      .ZERO_R0 (ZERO_R0),
      .DEPTH   (DEPTH)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .bset      (bset),
      .bset_addr (bset_addr),
      .we0       (we0),
      .waddr0    (waddr0),
      .we1       (we1),
      .waddr1    (waddr1),
      .busy      (busy)
   );

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd;

      assign ra = raddr[k*ADDR_W +: ADDR_W];

      // Bypass also honours the R0 drop; reset masks everything so no write data leaks out.
      always_comb begin
         rd = mem[ra];
         if (BYPASS != 0) begin
            if (wr0_ok && waddr0 == ra)
               rd = wdata0;
            if (wr1_ok && waddr1 == ra)
               rd = wdata1;
         end
         if (!rst || (ZERO_R0 != 0 && ra == R0))
            rd = '0;
      end

      assign rdata[k*DATA_W +: DATA_W] = rd;
      assign rd_busy[k]                = busy[ra];
   end

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - directed checks of register_file_mp in three parameterisations
module tb_register_file_mp;
   import rf_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        we0, we1, bset;
   logic [2:0]  waddr0, waddr1, bset_addr;
   logic [15:0] wdata0, wdata1;
   logic [5:0]  raddr;

   logic [31:0] rdata_a, rdata_b, rdata_z;
   logic [1:0]  rd_busy_a, rd_busy_b, rd_busy_z;
   logic [7:0]  busy_a, busy_b, busy_z;

   int n_total  = 0;
   int n_passed = 0;

   always #5 clk = ~clk;

   register_file_mp #(.ZERO_R0(0), .BYPASS(1)) dut_a (
      .clk(clk), .rst(rst), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
      .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .raddr(raddr),
      .rdata(rdata_a), .rd_busy(rd_busy_a), .bset(bset), .bset_addr(bset_addr), .busy(busy_a));

   register_file_mp #(.ZERO_R0(0), .BYPASS(0)) dut_b (
      .clk(clk), .rst(rst), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
      .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .raddr(raddr),
      .rdata(rdata_b), .rd_busy(rd_busy_b), .bset(bset), .bset_addr(bset_addr), .busy(busy_b));

   register_file_mp #(.ZERO_R0(1), .BYPASS(1)) dut_z (
      .clk(clk), .rst(rst), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
      .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .raddr(raddr),
      .rdata(rdata_z), .rd_busy(rd_busy_z), .bset(bset), .bset_addr(bset_addr), .busy(busy_z));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp)
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      else
         n_passed++;
   endtask

   task automatic drive_w0(input wr_port_t p);
      we0    = p.we;
      waddr0 = p.addr;
      wdata0 = p.data;
   endtask

   task automatic drive_w1(input wr_port_t p);
      we1    = p.we;
      waddr1 = p.addr;
      wdata1 = p.data;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      drive_w0('{we: 1'b0, addr: 3'd0, data: 16'h0});
      drive_w1('{we: 1'b0, addr: 3'd0, data: 16'h0});
      bset      = 1'b0;
      bset_addr = 3'd0;
   endtask

   initial begin
      rst = 1'b0;
      idle();
      raddr = {3'd0, 3'd1};
      drive_w0('{we: 1'b1, addr: 3'd1, data: 16'hfee5});
      repeat (4) begin
         #10 wdata0 = ~wdata0;
      end
      check("rst_rdata", rdata_a, 32'h0);
      check("rst_busy", {24'h0, busy_a}, 32'h0);
      check("rst_rd_busy", {30'h0, rd_busy_a}, 32'h0);

      idle();
      #2 rst = 1'b1;
      #1 check("rst_no_write_r1", {16'h0, rdata_a[15:0]}, 32'h0);

      // Release then ordinary write of R1
      tick();
      drive_w0('{we: 1'b1, addr: 3'd1, data: 16'h5342});
      tick();
      idle();
      #1 check("write_r1", {16'h0, rdata_a[15:0]}, 32'h5342);

      // Same-address collision, port 1 wins
      drive_w0('{we: 1'b1, addr: 3'd3, data: 16'h1111});
      drive_w1('{we: 1'b1, addr: 3'd3, data: 16'h2222});
      raddr = {3'd1, 3'd3};
      #1 check("byp_pri_p1", {16'h0, rdata_a[15:0]}, 32'h2222);
      check("nobyp_old_r3", {16'h0, rdata_b[15:0]}, 32'h0);
      tick();
      idle();
      #1 check("conflict_a", {16'h0, rdata_a[15:0]}, 32'h2222);
      check("conflict_b", {16'h0, rdata_b[15:0]}, 32'h2222);
      check("busy_nonbusy_write", {24'h0, busy_a}, 32'h0);

      // Write-through bypass on port 0, port 1 unaffected
      drive_w0('{we: 1'b1, addr: 3'd2, data: 16'ha334});
      raddr = {3'd3, 3'd2};
      #1 check("byp_r2", rdata_a, 32'h2222_a334);
      check("nobyp_r2", rdata_b, 32'h2222_0000);
      tick();
      idle();
      #1 check("nobyp_after_edge", rdata_b, 32'h2222_a334);

      // R0 write plus busy-set: hardwired zero vs ordinary R0
      drive_w0('{we: 1'b1, addr: 3'd0, data: 16'h0bb5});
      bset      = 1'b1;
      bset_addr = 3'd0;
      raddr     = {3'd2, 3'd0};
      #1 check("z_r0_byp", {16'h0, rdata_z[15:0]}, 32'h0);
      check("a_r0_byp", {16'h0, rdata_a[15:0]}, 32'h0bb5);
      tick();
      idle();
      #1 check("z_r0_read", {16'h0, rdata_z[15:0]}, 32'h0);
      check("z_busy", {24'h0, busy_z}, 32'h0);
      check("a_r0_read", {16'h0, rdata_a[15:0]}, 32'h0bb5);
      check("a_busy_r0_set_wins", {24'h0, busy_a}, 32'h01);
      drive_w1('{we: 1'b1, addr: 3'd0, data: 16'h0});
      tick();
      idle();
      #1 check("a_busy_r0_cleared", {24'h0, busy_a}, 32'h0);

      // Scoreboard set, set-over-clear, then clear
      bset      = 1'b1;
      bset_addr = 3'd4;
      tick();
      idle();
      raddr = {3'd4, 3'd2};
      #1 check("sb_set_r4", {24'h0, busy_a}, 32'h10);
      check("sb_rd_busy", {30'h0, rd_busy_a}, 32'h2);
      bset      = 1'b1;
      bset_addr = 3'd4;
      drive_w1('{we: 1'b1, addr: 3'd4, data: 16'h4444});
      #1 check("sb_rd_busy_not_bypassed", {30'h0, rd_busy_a}, 32'h2);
      check("sb_data_bypassed", {16'h0, rdata_a[31:16]}, 32'h4444);
      tick();
      idle();
      #1 check("sb_set_beats_clear", {24'h0, busy_a}, 32'h10);
      drive_w0('{we: 1'b1, addr: 3'd4, data: 16'h0404});
      #1 check("sb_before_clear_edge", {24'h0, busy_a}, 32'h10);
      tick();
      idle();
      #1 check("sb_cleared", {24'h0, busy_a}, 32'h0);
      check("sb_rd_busy_clear", {30'h0, rd_busy_a}, 32'h0);
      check("sb_r4_data", {16'h0, rdata_a[31:16]}, 32'h0404);

      // Async reset in the middle of a cycle
      bset      = 1'b1;
      bset_addr = 3'd5;
      tick();
      bset_addr = 3'd6;
      tick();
      idle();
      #1 check("mid_busy_56", {24'h0, busy_a}, 32'h60);
      drive_w0('{we: 1'b1, addr: 3'd5, data: 16'h5555});
      tick();
      idle();
      raddr = {3'd4, 3'd5};
      #1 check("mid_r5", rdata_a, 32'h0404_5555);
      drive_w0('{we: 1'b1, addr: 3'd5, data: 16'h9999});
      #1 rst = 1'b0;
      #1 check("async_busy", {24'h0, busy_a}, 32'h0);
      check("async_rdata", rdata_a, 32'h0);
      check("async_busy_b", {24'h0, busy_b}, 32'h0);
      tick();
      idle();
      rst = 1'b1;
      #1 check("async_r5_lost", rdata_a, 32'h0);
      check("async_rd_busy", {30'h0, rd_busy_a}, 32'h0);

      $display("%0d/%0d checks passed", n_passed, n_total);
      $finish;
   end

endmodule
